// File: rtl/reg_file_rd.sv
// reg_file_rd: 2R/1W register file with registered read ports, write bypass and load-use scoreboard.
module reg_file_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              Rd_En,
  input  logic [ADDR_W-1:0] Rd_Addr1,
  input  logic [ADDR_W-1:0] Rd_Addr2,
  output logic [DATA_W-1:0] Rd_Data1,
  output logic [DATA_W-1:0] Rd_Data2,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Mark_En,
  input  logic [ADDR_W-1:0] Mark_Addr,
  input  logic              Flush,
  output logic              Stall
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] rd1_q, rd2_q, rd1_d, rd2_d, val1, val2;
  logic              hit1, hit2, pend1, pend2, cap;
  assign hit1  = Wr_En && (Wr_Addr == Rd_Addr1);
  assign hit2  = Wr_En && (Wr_Addr == Rd_Addr2);
  assign val1  = (Rd_Addr1 == '0) ? '0 : hit1 ? Wr_Data : mem_q[Rd_Addr1];
  assign val2  = (Rd_Addr2 == '0) ? '0 : hit2 ? Wr_Data : mem_q[Rd_Addr2];
  // A register being written back this cycle is served by the bypass, so it never stalls.
  assign pend1 = busy_q[Rd_Addr1] && !hit1;
  assign pend2 = busy_q[Rd_Addr2] && !hit2;
  assign Stall = Rd_En && (pend1 || pend2);
  assign cap   = Rd_En && !Stall;
  assign rd1_d = cap ? val1 : rd1_q;
  assign rd2_d = cap ? val2 : rd2_q;
  assign Rd_Data1 = rd1_q;
  assign Rd_Data2 = rd2_q;
  // Mark is applied after the writeback clear so a newer outstanding load wins.
  always_comb begin
    busy_d = busy_q;
    if (Wr_En) busy_d[Wr_Addr] = 1'b0;
    if (Mark_En) busy_d[Mark_Addr] = 1'b1;
    if (Flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
    end else begin
      if (Wr_En && Wr_Addr != '0) mem_q[Wr_Addr] <= Wr_Data;
      busy_q <= busy_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
    end
  end
endmodule

// File: tb/tb_reg_file_rd.sv
// tb_reg_file_rd: scoreboard bench for reg_file_rd against an array-based reference model.
module tb_reg_file_rd;
  logic        clk = 0, rst_n = 0;
  logic        rd_en = 0, wr_en = 0, mark_en = 0, flush = 0;
  logic [4:0]  rd_addr1 = 0, rd_addr2 = 0, wr_addr = 0, mark_addr = 0;
  logic [31:0] wr_data = 0, rd_data1, rd_data2;
  logic        stall;
  reg_file_rd #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(clk), .Rst_N(rst_n), .Rd_En(rd_en), .Rd_Addr1(rd_addr1), .Rd_Addr2(rd_addr2),
    .Rd_Data1(rd_data1), .Rd_Data2(rd_data2), .Wr_En(wr_en), .Wr_Addr(wr_addr),
    .Wr_Data(wr_data), .Mark_En(mark_en), .Mark_Addr(mark_addr), .Flush(flush), .Stall(stall)
  );
  always #5 clk = ~clk;
  int cmp = 0, bad = 0;
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  logic [63:0] exp_q [$];
  logic [31:0] cur1 = 0, cur2 = 0;
  logic        mon_cap;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction
  function automatic bit model_pend(input logic [4:0] a, input bit we, input logic [4:0] wa);
    return a != 0 && m_busy[a] && !(we && wa == a);
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0;
      m_busy[i] = 0;
    end
  endtask
  // One cycle, entered and left at a falling edge.
  task automatic cyc(input bit re, input logic [4:0] a1, input logic [4:0] a2,
                     input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit me, input logic [4:0] ma, input bit fl);
    bit es;
    rd_en = re; rd_addr1 = a1; rd_addr2 = a2; wr_en = we; wr_addr = wa; wr_data = wd;
    mark_en = me; mark_addr = ma; flush = fl;
    #1;
    es = re && (model_pend(a1, we, wa) || model_pend(a2, we, wa));
    check("stall", {31'b0, stall}, {31'b0, es});
    if (re && !es) exp_q.push_back({model_rd(a1, we, wa, wd), model_rd(a2, we, wa, wd)});
    @(posedge clk);
    if (we && wa != 0) m_mem[wa] = wd;
    if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 0;
    else begin
      if (we) m_busy[wa] = 0;
      if (me && ma != 0) m_busy[ma] = 1;
    end
    @(negedge clk);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      cur1 = 0;
      cur2 = 0;
    end else begin
      mon_cap = rd_en && !stall;
      #1;
      if (mon_cap) begin
        if (exp_q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL capture: got unexpected capture expected none queued");
        end else {cur1, cur2} = exp_q.pop_front();
      end
      check("rd_data1", rd_data1, cur1);
      check("rd_data2", rd_data2, cur2);
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd1", rd_data1, 0);
    check("reset_stall", {31'b0, stall}, 0);
    rst_n = 1;
    cyc(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
    cyc(1, 0, 5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 32'h11, 0, 0, 0);
    cyc(1, 7, 5, 1, 7, 32'h22, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc(1, 9, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 9, 0, 1, 9, 32'hA5, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 32'h7, 1, 3, 0);
    cyc(1, 0, 3, 0, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 1, 3, 32'h7, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 32'h44, 0, 0, 0);
    cyc(0, 0, 0, 1, 6, 32'h66, 1, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 6, 0);
    cyc(1, 4, 6, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 1);
    cyc(1, 4, 6, 0, 0, 0, 0, 0, 0);
    cyc(1, 6, 4, 0, 0, 0, 1, 6, 0);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    for (int k = 1; k < 8; k++) cyc(0, 0, 0, 1, 5'(k), 32'h100 + k, 0, 0, 0);
    cyc(1, 5, 6, 0, 0, 0, 1, 2, 0);
    #2 rst_n = 0;
    #1;
    check("async_rst_rd1", rd_data1, 0);
    check("async_rst_rd2", rd_data2, 0);
    rd_en = 1; rd_addr1 = 2; rd_addr2 = 2;
    #1 check("rst_stall", {31'b0, stall}, 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    model_clear();
    rst_n = 1;
    cyc(1, 5, 2, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    check("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
